// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the bit-serial adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// rtl/serial_adder_full_adder_cell.sv - half-adder and the per-bit full-adder cell built from two of them
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one bit per clock, LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             cout_r;
    logic [CNT_W-1:0] count;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last_bit;

    full_adder_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    assign ready    = (state == IDLE) || (state == DONE);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign accept   = ready && start;
    assign last_bit = (count == CNT_W'(WIDTH - 1));
    assign sum      = sum_sr;
    assign cout     = cout_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                carry  <= cin;
                count  <= '0;
                sum_sr <= '0;
                cout_r <= 1'b0;
            end else if (state == RUN) begin
                // Sum enters at the MSB so bit k settles at sum[k] after WIDTH shifts.
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
                carry  <= bit_c;
                count  <= count + 1'b1;
                if (last_bit)
                    cout_r <= bit_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a = av;
        b = bv;
        cin = cv;
        start = 1'b1;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt, output bit found);
        cyc = 0;
        busy_cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            cyc++;
            if (busy) busy_cnt++;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ready, busy, done, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got ready=%b busy=%b done=%b sum=%h cout=%b, want 1 0 0 00 0",
                     ready, busy, done, sum, cout);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_idle: got ready=%b busy=%b done=%b, want 1 0 0", ready, busy, done);
        end
    endtask

    task automatic test_add(input string name, input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input logic [7:0] es, input logic ec);
        int cyc, bc;
        bit found;
        start_op(av, bv, cv);
        wait_done(cyc, bc, found);
        n_cmp++;
        if (!found || cyc !== 9 || bc !== 8) begin
            n_err++;
            $display("FAIL %s_latency: got found=%0d done_cycle=%0d busy_cycles=%0d, want 1 9 8",
                     name, found, cyc, bc);
        end
        n_cmp++;
        if (sum !== es || cout !== ec) begin
            n_err++;
            $display("FAIL %s_result: got sum=%h cout=%b, want sum=%h cout=%b", name, sum, cout, es, ec);
        end
        tick();
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL %s_after: got ready=%b busy=%b done=%b, want 1 0 0", name, ready, busy, done);
        end
    endtask

    task automatic test_hold();
        test_add("zero_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || sum !== 8'h01 || cout !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: got done=%b sum=%h cout=%b, want 0 01 0", i, done, sum, cout);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int pulses = 0;
        logic [7:0] s_at_done = 8'hxx;
        logic c_at_done = 1'bx;
        start_op(8'h10, 8'h20, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) start = 1'b0;
            if (i == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                pulses++;
                s_at_done = sum;
                c_at_done = cout;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL ignore_pulses: got %0d done pulses, want 1", pulses);
        end
        n_cmp++;
        if (s_at_done !== 8'h30 || c_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result: got sum=%h cout=%b, want sum=30 cout=0", s_at_done, c_at_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        bit found;
        start_op(8'h80, 8'h80, 1'b0);
        wait_done(cyc, bc, found);
        n_cmp++;
        if (!found || sum !== 8'h00 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: got found=%0d sum=%h cout=%b, want 1 00 1", found, sum, cout);
        end
        start_op(8'h01, 8'h02, 1'b0);
        n_cmp++;
        if (ready !== 1'b1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: got ready=%b done=%b, want 1 1", ready, done);
        end
        wait_done(cyc, bc, found);
        n_cmp++;
        if (!found || cyc !== 9) begin
            n_err++;
            $display("FAIL b2b_latency: got found=%0d done_cycle=%0d, want 1 9", found, cyc);
        end
        n_cmp++;
        if (sum !== 8'h03 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: got sum=%h cout=%b, want 03 0", sum, cout);
        end
        tick();
    endtask

    task automatic test_abort();
        int pulses = 0;
        start_op(8'hAA, 8'h55, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({ready, busy, done, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL abort_state: got ready=%b busy=%b done=%b sum=%h cout=%b, want 1 0 0 00 0",
                     ready, busy, done, sum, cout);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_nodone: got %0d done pulses busy=%b, want 0 0", pulses, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #1;
        test_reset();
        test_add("basic", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
        test_add("overflow", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_add("alt_cin", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
        test_hold();
        test_ignore_busy();
        test_back_to_back();
        test_abort();
        test_add("post_abort", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
